// File: rtl/spi_master_ctrl_if.sv
// Host command/response bundle for spi_master_ctrl.
// The host drives commands on the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [9:0] cmd_data;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       cmd_err;
   logic       busy;

   modport master (
      output cmd_valid, cmd_data,
      input  cmd_ready, rd_data, rd_valid, cmd_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_data,
      output cmd_ready, rd_data, rd_valid, cmd_err, busy
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master framing 10-bit host commands onto SS_n/MOSI and collecting read bytes from MISO.
// Optional read-address tracking with command rejection: define SPI_MASTER_RD_TRACK_EN.
module spi_master_ctrl #(
   parameter int unsigned RD_WAIT    = 2,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   spi_master_ctrl_if.slave   host,
   output logic               SS_n,
   output logic               MOSI,
   input  logic               MISO
);

   localparam int unsigned CntW = 8;
   localparam logic [CntW-1:0] WaitLast = CntW'(RD_WAIT - 1);
   localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES);
   localparam logic [CntW-1:0] GapPost  = CntW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StSel, StCmd, StShift, StWait, StRecv, StGap} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] gap_q, gap_d;
   logic [9:0]      cmd_q, cmd_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            ss_n_q, ss_n_d;
   logic            mosi_q, mosi_d;
   logic            ready_q, ready_d;
   logic            busy_q, busy_d;
   logic            rd_valid_q, rd_valid_d;
   logic            accept, reject, frame_end;

   assign accept = host.cmd_valid & ready_q;

`ifdef SPI_MASTER_RD_TRACK_EN
   logic trk_q, err_q;

   assign reject = (host.cmd_data[9:8] == 2'b11) && !trk_q;

   // Sticky once any rd-addr frame has been fully shifted out.
   always_ff @(posedge clk) begin
      if (rst) begin
         trk_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         err_q <= accept & reject;
         if (state_q == StShift && cnt_q == '0 && cmd_q[9:8] == 2'b10) trk_q <= 1'b1;
      end
   end

   assign host.cmd_err = err_q;
`else
   assign reject       = 1'b0;
   assign host.cmd_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      cmd_d      = cmd_q;
      shift_d    = shift_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      frame_end  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else if (accept) begin
               cmd_d = host.cmd_data;
               if (!reject) state_d = StSel;
            end
         end
         StSel: state_d = StCmd;
         StCmd: begin
            state_d = StShift;
            cnt_d   = CntW'(9);
         end
         StShift: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (cmd_q[9:8] == 2'b11) begin
               state_d = StWait;
               cnt_d   = WaitLast;
            end else begin
               frame_end = 1'b1;
            end
         end
         StWait: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StRecv;
               cnt_d   = CntW'(7);
            end
         end
         StRecv: begin
            shift_d = {shift_q[6:0], MISO};
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               frame_end  = 1'b1;
               rd_data_d  = {shift_q[6:0], MISO};
               rd_valid_d = 1'b1;
            end
         end
         StGap: begin
            gap_d = gap_q - 1'b1;
            if (gap_q == CntW'(1)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // The first SS_n-high cycle already counts toward the gap.
      if (frame_end) begin
         gap_d   = GapPost;
         state_d = (GAP_CYCLES > 1) ? StGap : StIdle;
      end

      ss_n_d = !(state_d inside {StSel, StCmd, StShift, StWait, StRecv});
      case (state_d)
         StSel, StCmd: mosi_d = cmd_d[9];
         StShift:      mosi_d = cmd_d[cnt_d[3:0]];
         default:      mosi_d = 1'b0;
      endcase
      ready_d = (state_d == StIdle) && (gap_d == '0) && !accept;
      busy_d  = (state_d != StIdle) || (gap_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         gap_q      <= GapLoad;
         cmd_q      <= '0;
         shift_q    <= '0;
         rd_data_q  <= '0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         cmd_q      <= cmd_d;
         shift_q    <= shift_d;
         rd_data_q  <= rd_data_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign SS_n          = ss_n_q;
   assign MOSI          = mosi_q;
   assign host.cmd_ready = ready_q;
   assign host.busy     = busy_q;
   assign host.rd_data  = rd_data_q;
   assign host.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: every accepted command expands into an expected
// per-cycle waveform queue that the DUT outputs are compared against.
module tb_spi_master_ctrl;
   localparam int unsigned RD_WAIT = 2;
   localparam int unsigned GAP     = 1;

   logic clk = 1'b0;
   logic rst;
   logic MISO;
   logic SS_n, MOSI;

   spi_master_ctrl_if bus ();

   spi_master_ctrl #(
      .RD_WAIT    (RD_WAIT),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .host (bus.slave),
      .SS_n (SS_n),
      .MOSI (MOSI),
      .MISO (MISO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ss_n;
      logic       mosi;
      logic       ready;
      logic       busy;
      logic       rv;
      logic       err;
      logic       miso;
      logic [7:0] rbyte;
   } exp_t;

   exp_t       q[$];
   exp_t       cur;
   logic [7:0] rd_exp;
   bit         trk;
   bit         acc_seen;
   int         pin_byte = -1;
   int         errors = 0;
   int         checks = 0;

   int         lo_run = 0, hi_run = 0, last_lo = 0, last_hi = 0, rv_cnt = 0;
   logic [9:0] mosi_cap = '0;
   logic       c1_bit = 1'b0;
   logic [7:0] rv_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk_hi(input logic ready, input logic rv, input logic [7:0] b);
      exp_t e;
      e.ss_n = 1'b1; e.mosi = 1'b0; e.ready = ready; e.busy = !ready;
      e.rv = rv; e.err = 1'b0; e.miso = 1'($urandom_range(0, 1)); e.rbyte = b;
      return e;
   endfunction

   // Expand one accepted command into the cycles that must follow it.
   task automatic push_cmd(input logic [9:0] c);
      exp_t       e;
      logic [7:0] b;
      bit         rd;
      int         len;
      rd = (c[9:8] == 2'b11);
`ifdef SPI_MASTER_RD_TRACK_EN
      if (rd && !trk) begin
         e = mk_hi(1'b0, 1'b0, 8'h00);
         e.busy = 1'b0;
         e.err  = 1'b1;
         q.push_back(e);
         return;
      end
`endif
      if (c[9:8] == 2'b10) trk = 1'b1;
      b   = (pin_byte >= 0) ? 8'(pin_byte) : 8'($urandom);
      len = rd ? 20 + RD_WAIT : 12;
      for (int k = 0; k < len; k++) begin
         e = mk_hi(1'b0, 1'b0, 8'h00);
         e.ss_n = 1'b0;
         e.mosi = (k < 2) ? c[9] : (k < 12) ? c[11 - k] : 1'b0;
         if (rd && k >= 12 + int'(RD_WAIT)) e.miso = b[7 - (k - 12 - int'(RD_WAIT))];
         q.push_back(e);
      end
      if (GAP == 1) begin
         if (rd) q.push_back(mk_hi(1'b1, 1'b1, b));
      end else begin
         for (int i = 0; i < int'(GAP) - 1; i++) q.push_back(mk_hi(1'b0, rd && i == 0, b));
      end
   endtask

   task automatic model_edge();
      acc_seen = 1'b0;
      if (rst) begin
         q.delete();
         for (int i = 0; i < int'(GAP); i++) q.push_back(mk_hi(1'b0, 1'b0, 8'h00));
         trk    = 1'b0;
         rd_exp = 8'h00;
      end else begin
         if (bus.cmd_valid && cur.ready) acc_seen = 1'b1;
         if (q.size() > 0) void'(q.pop_front());
         if (acc_seen) push_cmd(bus.cmd_data);
      end
      cur = (q.size() > 0) ? q[0] : mk_hi(1'b1, 1'b0, 8'h00);
      if (cur.rv) rd_exp = cur.rbyte;
   endtask

   task automatic check_outputs();
      chk("SS_n", SS_n, cur.ss_n);
      chk("MOSI", MOSI, cur.mosi);
      chk("cmd_ready", bus.cmd_ready, cur.ready);
      chk("busy", bus.busy, cur.busy);
      chk("rd_valid", bus.rd_valid, cur.rv);
      chk("cmd_err", bus.cmd_err, cur.err);
      chk("rd_data", bus.rd_data, rd_exp);
      if (SS_n === 1'b0) begin
         if (lo_run == 0) last_hi = hi_run;
         lo_run++;
         hi_run = 0;
         if (lo_run == 2) c1_bit = MOSI;
         if (lo_run >= 3 && lo_run <= 12) mosi_cap = {mosi_cap[8:0], MOSI};
      end else begin
         if (lo_run != 0) last_lo = lo_run;
         lo_run = 0;
         hi_run++;
      end
      if (bus.rd_valid === 1'b1) begin
         rv_cnt++;
         rv_data = bus.rd_data;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
      MISO = cur.miso;
   endtask

   task automatic send(input logic [9:0] c, input bit hold);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = c;
      do begin
         cycle();
         n++;
      end while (!acc_seen && n < 200);
      if (!acc_seen) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: cmd %0h not accepted, required within 200 cycles", c);
      end
      if (!hold) bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() > 0 || !cur.ready) && n < 200) begin
         cycle();
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: expected idle within 200 cycles");
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cycle();
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required to end on its own");
      $fatal(1);
   end

   initial begin
      int rv0, n;
      cur = mk_hi(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      MISO = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;

      // Reset and the post-reset gap.
      do_reset(3);
      chk("ready_after_reset", bus.cmd_ready, 1'b0);
      cycle();
      chk("ready_rise", bus.cmd_ready, 1'b1);

      // Write-address frame.
      rv0 = rv_cnt;
      send(10'h00A, 1'b0);
      wait_idle();
      chk("wr_addr_len", last_lo, 12);
      chk("wr_addr_mosi", mosi_cap, 10'h00A);
      chk("wr_addr_no_rv", rv_cnt, rv0);

      // Write-data, rd-addr, rd-data with the slave returning 8'hA5.
      send(10'h1A5, 1'b0);
      wait_idle();
      chk("wr_data_mosi", mosi_cap, 10'h1A5);
      send(10'h20A, 1'b0);
      wait_idle();
      rv0 = rv_cnt;
      pin_byte = 8'hA5;
      send(10'h300, 1'b0);
      wait_idle();
      pin_byte = -1;
      chk("rd_len", last_lo, 22);
      chk("rd_rv_once", rv_cnt, rv0 + 1);
      chk("rd_byte", rv_data, 8'hA5);
      repeat (3) cycle();
      chk("rd_hold", bus.rd_data, 8'hA5);

      // Back-to-back commands held valid.
      send(10'h1FF, 1'b1);
      send(10'h2F0, 1'b0);
      wait_idle();
      chk("b2b_gap", last_hi, 1);
      chk("b2b_c1", c1_bit, 1'b1);

      // Reset at c7 of a rd-data frame.
      rv0 = rv_cnt;
      send(10'h311, 1'b0);
      n = 0;
      while (lo_run != 8 && n < 50) begin
         cycle();
         n++;
      end
      chk("abort_reach_c7", lo_run, 8);
      do_reset(1);
      chk("abort_ss", SS_n, 1'b1);
      repeat (30) cycle();
      chk("abort_no_rv", rv_cnt, rv0);
      send(10'h0C3, 1'b0);
      wait_idle();
      chk("after_abort_len", last_lo, 12);
      chk("after_abort_mosi", mosi_cap, 10'h0C3);

`ifdef SPI_MASTER_RD_TRACK_EN
      do_reset(2);
      cycle();
      send(10'h300, 1'b0);
      chk("reject_err", bus.cmd_err, 1'b1);
      chk("reject_ss", SS_n, 1'b1);
      cycle();
      chk("reject_ready", bus.cmd_ready, 1'b1);
`endif

      // Randomized traffic with occasional resets, including mid-frame.
      for (int i = 0; i < 300; i++) begin
         logic [9:0] c;
         c = 10'($urandom);
         repeat ($urandom_range(0, 3)) cycle();
         send(c, 1'b0);
         if ($urandom_range(0, 15) == 0) begin
            repeat ($urandom_range(0, 25)) cycle();
            do_reset($urandom_range(1, 2));
         end
      end
      wait_idle();
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Single-clock SPI master that builds the serial frames consumed by the spi_slave front end of the SPI-to-RAM path. It accepts 10-bit commands from a host interface, drives SS_n and MOSI, and samples MISO for read-data frames. For every read-data command it returns the 8-bit RAM byte to the host. MOSI/MISO shift on the system clock, so the host side and the serial side share one clock domain.

Parameters:
RD_WAIT, 2, cycles between the last MOSI bit cycle and the first MISO sample cycle (min 1); covers slave rx_valid, RAM tx_valid and MISO register latency.
GAP_CYCLES, 1, minimum SS_n-high cycles between frames (min 1); gives the slave time to return to IDLE and clear its counters.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  host command strobe
cmd_ready  out  1  high when a command can be accepted
cmd_data  in  10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload
rd_data  out  8  byte returned by a rd-data frame
rd_valid  out  1  one-cycle pulse, rd_data valid
cmd_err  out  1  one-cycle pulse, command rejected (optional feature only; tied 0 otherwise)
busy  out  1  frame in progress or gap not finished
SS_n  out  1  slave select, active-low
MOSI  out  1  serial data to slave
MISO  in  1  serial data from slave

Behaviour:
- Reset (rst=1 at a rising edge): SS_n=1, MOSI=0, rd_data=0, rd_valid=0, cmd_err=0, state IDLE. The gap counter is loaded so that SS_n stays high for at least GAP_CYCLES after reset. cmd_ready is 0 until the gap expires. Reset mid-frame aborts the frame: SS_n goes high at that edge and no rd_valid is produced.
- States: IDLE, SEL, CMD, SHIFT, WAIT, RECV, GAP. All outputs are registered.
- Handshake: cmd_ready=1 only in IDLE with the gap expired. The command is accepted on the edge where cmd_valid and cmd_ready are both high. cmd_data is latched at that edge, and cmd_ready drops on the next cycle.
- Frame timing, counted in cycles c0.. while SS_n is low:
  - c0 (SEL): MOSI=cmd[9].
  - c1 (CMD): MOSI=cmd[9]. This is the command bit the slave checks.
  - c2..c11 (SHIFT): MOSI=cmd[9] down to cmd[0], MSB first, 10 cycles.
- Write and rd-addr frames (opcode != 11): SS_n returns high after c11, so the frame is 12 low cycles. Then GAP.
- Rd-data frames (opcode 11):
  - WAIT covers c12..c(11+RD_WAIT) with MOSI=0.
  - RECV samples MISO at the end of cycles c(12+RD_WAIT)..c(19+RD_WAIT), into rd_data[7] down to rd_data[0].
  - SS_n goes high after the last sample. rd_valid pulses on the following cycle with the full byte. Then GAP.
- MOSI=0 whenever SS_n=1.
- GAP: SS_n=1 for GAP_CYCLES cycles, then IDLE. busy=1 in every state except IDLE.
- rd_data holds its value until the next rd-data frame completes.
- cmd_valid while cmd_ready=0 is ignored; the host must hold cmd_valid.
- MISO is not interpreted outside RECV.

Optional Feature:
SPI_MASTER_RD_TRACK_EN
- Defined:
  - An internal rd_addr_sent flag is set by a completed rd-addr frame and cleared by rst.
  - An opcode-11 command accepted while the flag is 0 is not transmitted. SS_n stays 1, cmd_err pulses one cycle after acceptance, and the block returns to IDLE. It does not enter GAP, since no frame was sent.
  - The flag is not cleared by rd-data frames, which matches the slave's sticky read-address behaviour.
- Undefined: all opcodes are transmitted, cmd_err is tied 0, and no flag is implemented.

Test Plan:
1. Reset for 3 cycles, then release. SS_n=1 and MOSI=0 throughout. cmd_ready rises after GAP_CYCLES=1 cycle.
2. Write-address frame: cmd_data=10'h00A. SS_n is low for exactly 12 cycles. MOSI sequence is 0,0,0,0,0,0,1,0,1,0 in c2..c11. The slave shows rx_data=10'h00A with rx_valid. No rd_valid.
3. Write-data frame: cmd_data=10'h1A5, then rd-addr 10'h20A, then rd-data 10'h300. RECV samples MISO with RAM preloaded to 8'hA5 at address 8'h0A. rd_valid pulses once with rd_data=8'hA5. SS_n is low for 20+RD_WAIT=22 cycles.
4. Back-to-back: two commands held valid. SS_n is high for exactly GAP_CYCLES cycles between frames, and the second frame's c1 MOSI equals its cmd[9].
5. Assert rst at c7 of a rd-data frame. SS_n=1 on the next cycle, no rd_valid, and the next command completes normally after the gap.
6. With SPI_MASTER_RD_TRACK_EN, issue rd-data 10'h300 right after reset. cmd_err pulses, SS_n never goes low, and cmd_ready returns within 2 cycles.
